// File: rtl/conf_channel_deserializer.sv
// Assembles NWORDS consecutive NIN-bit conf channel words (LS first) into one NOUT-bit output word.
// Optional idle timeout for partial words is built in when CONF_DESER_TIMEOUT_EN is defined.
module conf_channel_deserializer #(
  parameter int NIN     = 16,
  parameter int NOUT    = 40,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_v,
  input  logic [NIN-1:0]  in_d,
  output logic            in_a,
  output logic            out_v,
  output logic [NOUT-1:0] out_d,
  input  logic            out_a,
  output logic            timeout_drop
);

  localparam int NWORDS = (NOUT + NIN - 1) / NIN;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LASTLO = (NWORDS - 1) * NIN;
  localparam int LASTW  = NOUT - LASTLO;

  typedef enum logic {COLLECT, FULL} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [NOUT-1:0] buffer;
  logic            accept;
  logic            last_word;
  logic            expire;
  logic            unused_in_bits;

  assign accept    = in_v && (state == COLLECT);
  assign last_word = (count == CW'(NWORDS - 1));
  // The last slot may be narrower than NIN; its excess input bits are simply discarded.
  assign unused_in_bits = ^in_d;

`ifdef CONF_DESER_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] idle;

  assign expire = (state == COLLECT) && (count != '0) && !accept && (idle == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      idle <= '0;
    else if ((state == COLLECT) && (count != '0) && !accept && !expire)
      idle <= idle + 1'b1;
    else
      idle <= '0;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 2);
  assign expire         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= COLLECT;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (accept && last_word) next_state = FULL;
      FULL:    if (out_a) next_state = COLLECT;
      default: next_state = COLLECT;
    endcase
  end

  always_comb begin
    in_a         = in_v && reset_n && (state == COLLECT);
    out_v        = (state == FULL);
    timeout_drop = expire;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (accept)
      count <= last_word ? '0 : count + 1'b1;
    else if (expire)
      count <= '0;
  end

  // Slots are overwritten in place and never cleared between words.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buffer <= '0;
    end else if (accept) begin
      for (int k = 0; k < NWORDS - 1; k++)
        if (count == CW'(k)) buffer[k*NIN +: NIN] <= in_d;
      if (last_word) buffer[NOUT-1:LASTLO] <= in_d[LASTW-1:0];
    end
  end

  assign out_d = buffer;

endmodule

// File: tb/tb_conf_channel_deserializer.sv
// Randomized self-checking bench for conf_channel_deserializer against a queue-based reference model.
// Timeout scenarios run only when CONF_DESER_TIMEOUT_EN is defined.
module tb_conf_channel_deserializer;

  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_v;
  logic [15:0] in_d;
  logic        in_a;
  logic        out_v;
  logic [39:0] out_d;
  logic        out_a;
  logic        timeout_drop;

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];
  bit          held = 0;
  logic [39:0] expWord = '0;
  int          idleRun = 0;

  always #5 clk = ~clk;

  conf_channel_deserializer #(.NIN(16), .NOUT(40), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .in_v(in_v), .in_d(in_d), .in_a(in_a),
    .out_v(out_v), .out_d(out_d), .out_a(out_a), .timeout_drop(timeout_drop)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks outputs mid-cycle, then advances the model at the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic a);
    logic expDrop;
    in_v  = v;
    in_d  = d;
    out_a = a;
    @(negedge clk);
`ifdef CONF_DESER_TIMEOUT_EN
    expDrop = (q.size() > 0) && !held && !v && (idleRun + 1 == TIMEOUT);
`else
    expDrop = 1'b0;
`endif
    checkOutput("in_a", in_a, v && !held);
    checkOutput("out_v", out_v, held);
    if (held) checkOutput("out_d", out_d, expWord);
    checkOutput("timeout_drop", timeout_drop, expDrop);
    @(posedge clk);
    if (v && !held) begin
      q.push_back(d);
      idleRun = 0;
      if (q.size() == 3) begin
        expWord = 40'(q[0]) + (40'(q[1]) << 16) + (40'(q[2] & 16'h00FF) << 32);
        held = 1;
        q.delete();
      end
    end else if (held && a) begin
      held = 0;
    end else if (q.size() > 0) begin
      idleRun++;
      if (expDrop) begin
        q.delete();
        idleRun = 0;
      end
    end
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #2;
    checkOutput("rst_in_a", in_a, 1'b0);
    checkOutput("rst_out_v", out_v, 1'b0);
    checkOutput("rst_out_d", out_d, 40'h0);
    checkOutput("rst_drop", timeout_drop, 1'b0);
    q.delete();
    held = 0;
    idleRun = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    in_v = 1'b1; in_d = 16'h0; out_a = 1'b0;
    #1;
    doReset();

    // T1: basic assembly with immediate output ack
    applyStimulus(1, 16'h1111, 1);
    applyStimulus(1, 16'h2222, 1);
    applyStimulus(1, 16'h0033, 1);
    checkOutput("T1_out_v", out_v, 1'b1);
    checkOutput("T1_word", out_d, 40'h33_2222_1111);
    applyStimulus(0, 16'h0, 1);
    checkOutput("T1_one_pulse", out_v, 1'b0);

    // T2: back-pressure while upstream keeps offering
    applyStimulus(1, 16'h0101, 0);
    applyStimulus(1, 16'h0202, 0);
    applyStimulus(1, 16'h0303, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 16'hDEAD, 0);
    checkOutput("T2_held_word", out_d, 40'h03_0202_0101);
    applyStimulus(1, 16'hBEEF, 1);
    applyStimulus(1, 16'h0001, 0);
    applyStimulus(1, 16'h0002, 0);
    applyStimulus(1, 16'h0003, 0);
    checkOutput("T2_next_word", out_d, 40'h03_0002_0001);
    applyStimulus(0, 16'h0, 1);

    // T3: high byte of the last word is dropped
    applyStimulus(1, 16'h5555, 0);
    applyStimulus(1, 16'h6666, 0);
    applyStimulus(1, 16'hABCD, 0);
    checkOutput("T3_top_byte", out_d[39:32], 8'hCD);
    applyStimulus(0, 16'h0, 1);

    // T4: reset mid-word discards the partial word
    applyStimulus(1, 16'h7777, 0);
    applyStimulus(1, 16'h8888, 0);
    doReset();
    applyStimulus(0, 16'h0, 0);
    checkOutput("T4_no_stale", out_v, 1'b0);
    applyStimulus(1, 16'h000A, 0);
    applyStimulus(1, 16'h000B, 0);
    applyStimulus(1, 16'h000C, 0);
    checkOutput("T4_word", out_d, 40'h0C_000B_000A);
    applyStimulus(0, 16'h0, 1);

`ifdef CONF_DESER_TIMEOUT_EN
    // T5: partial word expires after TIMEOUT idle cycles
    applyStimulus(1, 16'h1234, 0);
    for (int i = 0; i < TIMEOUT; i++) applyStimulus(0, 16'h0, 0);
    applyStimulus(1, 16'h0AAA, 0);
    applyStimulus(1, 16'h0BBB, 0);
    applyStimulus(1, 16'h00CC, 0);
    checkOutput("T5_word", out_d, 40'hCC_0BBB_0AAA);
    applyStimulus(0, 16'h0, 1);

    // T6: accept in the expiry cycle wins
    applyStimulus(1, 16'h1001, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 16'h0, 0);
    applyStimulus(1, 16'h2002, 0);
    applyStimulus(1, 16'h3003, 0);
    checkOutput("T6_word", out_d, 40'h03_2002_1001);
    applyStimulus(0, 16'h0, 1);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 99) == 0)
        for (int j = 0; j < TIMEOUT + 2; j++) applyStimulus(0, 16'h0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
